// File: rtl/uart_pkg.sv
// Shared types and constants for the UART transmit path.
package uart_pkg;

    typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} tx_state_t;

    localparam int PAR_NONE = 0;
    localparam int PAR_EVEN = 1;
    localparam int PAR_ODD  = 2;

    function automatic logic dataParity(input logic [7:0] data, input int nBits);
        logic p;
        p = 1'b0;
        for (int i = 0; i < 8; i++) begin
            if (i < nBits) p = p ^ data[i];
        end
        return p;
    endfunction

endpackage

// File: rtl/uart_baud_cnt.sv
// Bit-period counter: one-cycle tick on the last clock of every bit, held clear while disabled.
module uart_baud_cnt #(
    parameter int CLKS_PER_BIT = 434
) (
    input  logic iCLK_50,
    input  logic iRST,
    input  logic iEnable,
    output logic oTick
);

    localparam int CW = (CLKS_PER_BIT > 2) ? $clog2(CLKS_PER_BIT) : 1;
    localparam logic [CW-1:0] LAST = CW'(CLKS_PER_BIT - 1);

    logic [CW-1:0] count;

    always_ff @(posedge iCLK_50) begin
        if (iRST || !iEnable) begin
            count <= '0;
        end else if (count == LAST) begin
            count <= '0;
        end else begin
            count <= count + 1'b1;
        end
    end

    assign oTick = iEnable && (count == LAST);

endmodule

// File: rtl/uart_tx_serializer.sv
// Byte-wide UART transmitter: start bit, LSB-first data, optional parity, 1 or 2 stop bits.
module uart_tx_serializer #(
    parameter int CLKS_PER_BIT = 434,
    parameter int DATA_BITS    = 8,
    parameter int PARITY       = 0,
    parameter int STOP_BITS    = 1
) (
    input  logic       iCLK_50,
    input  logic       iRST,
    input  logic [7:0] iDATA,
    input  logic       iVALID,
    output logic       oREADY,
    output logic       oBUSY,
    output logic       oUART_TXD
);

    import uart_pkg::*;

    if (CLKS_PER_BIT < 2 || DATA_BITS < 5 || DATA_BITS > 8 || PARITY < 0 || PARITY > 2 ||
        (STOP_BITS != 1 && STOP_BITS != 2)) begin : gBadParams
        $error("uart_tx_serializer: illegal parameter combination");
    end

    localparam logic [2:0] LAST_DATA = 3'(DATA_BITS - 1);
    localparam logic [2:0] LAST_STOP = 3'(STOP_BITS - 1);

    tx_state_t  state;
    tx_state_t  nextState;
    logic [7:0] shiftReg;
    logic [2:0] bitIdx;
    logic       parityBit;
    logic       txdReg;
    logic       txdNext;
    logic       tick;
    logic       accept;
    logic       lastData;
    logic       lastStop;

    assign accept   = iVALID && (state == IDLE);
    assign lastData = (bitIdx == LAST_DATA);
    assign lastStop = (bitIdx == LAST_STOP);

    uart_baud_cnt #(
        .CLKS_PER_BIT(CLKS_PER_BIT)
    ) baudCnt (
        .iCLK_50(iCLK_50),
        .iRST   (iRST),
        .iEnable(state != IDLE),
        .oTick  (tick)
    );

    // The line is registered from the next state so the start bit leaves one cycle after accept.
    always_ff @(posedge iCLK_50) begin
        if (iRST) begin
            state     <= IDLE;
            shiftReg  <= '0;
            bitIdx    <= '0;
            parityBit <= 1'b0;
            txdReg    <= 1'b1;
        end else begin
            state  <= nextState;
            txdReg <= txdNext;
            if (accept) begin
                shiftReg  <= iDATA;
                parityBit <= dataParity(iDATA, DATA_BITS) ^ (PARITY == PAR_ODD);
                bitIdx    <= '0;
            end else if (tick) begin
                if (state == DATA) begin
                    shiftReg <= shiftReg >> 1;
                    bitIdx   <= lastData ? 3'd0 : bitIdx + 3'd1;
                end else if (state == STOP) begin
                    bitIdx <= lastStop ? 3'd0 : bitIdx + 3'd1;
                end
            end
        end
    end

    // The parameter PARITY shadows the enum literal, so the state is named through the package.
    always_comb begin
        nextState = state;
        case (state)
            IDLE:             if (iVALID) nextState = START;
            START:            if (tick) nextState = DATA;
            DATA:             if (tick && lastData)
                                  nextState = (PARITY != PAR_NONE) ? uart_pkg::PARITY : STOP;
            uart_pkg::PARITY: if (tick) nextState = STOP;
            STOP:             if (tick && lastStop) nextState = IDLE;
            default:          nextState = IDLE;
        endcase
    end

    always_comb begin
        txdNext = 1'b1;
        case (nextState)
            START:            txdNext = 1'b0;
            DATA:             txdNext = (state == DATA && tick) ? shiftReg[1] : shiftReg[0];
            uart_pkg::PARITY: txdNext = parityBit;
            default:          txdNext = 1'b1;
        endcase
    end

    assign oUART_TXD = txdReg;
    assign oREADY    = (state == IDLE);
    assign oBUSY     = (state != IDLE);

endmodule
